// File: rtl/seg_pkg.sv
// Shared glyph table and encodings for the multiplexed seven-segment display controller.
package seg_pkg;

  typedef enum logic {
    MODE_DEC = 1'b0,
    MODE_HEX = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_FINISH
  } conv_state_e;

  // Active-low patterns, bit 6..0 = a,b,c,d,e,f,g
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0:    glyph = 7'b0000001;
      4'h1:    glyph = 7'b1001111;
      4'h2:    glyph = 7'b0010010;
      4'h3:    glyph = 7'b0000110;
      4'h4:    glyph = 7'b1001100;
      4'h5:    glyph = 7'b0100100;
      4'h6:    glyph = 7'b0100000;
      4'h7:    glyph = 7'b0001111;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0000100;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b1100000;
      4'hC:    glyph = 7'b0110001;
      4'hD:    glyph = 7'b1000010;
      4'hE:    glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, result valid while done=1.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int VALUE_W = 16,
  parameter int DIGITS  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  // Internal BCD width covers the full input range so overflow can be detected
  localparam int BD_RAW = (VALUE_W * 3) / 10 + 1;
  localparam int BD     = (BD_RAW > DIGITS) ? BD_RAW : DIGITS;
  localparam int CNT_W  = $clog2(VALUE_W);

  conv_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [VALUE_W-1:0]   bin_q, bin_d;
  logic [4*BD-1:0]      bcd_q, bcd_d, adj;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CONV_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    adj     = bcd_q;
    for (int k = 0; k < BD; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
    case (state_q)
      CONV_IDLE: begin
        if (start) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        {bcd_d, bin_d} = {adj[4*BD-2:0], bin_q, 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = CONV_FINISH;
      end
      default: state_d = CONV_IDLE;
    endcase
  end

  assign busy = (state_q != CONV_IDLE);
  assign done = (state_q == CONV_FINISH);
  assign bcd  = bcd_q[4*DIGITS-1:0];

  generate
    if (BD > DIGITS) begin : g_ovf
      assign overflow = |bcd_q[4*BD-1:4*DIGITS];
    end else begin : g_no_ovf
      assign overflow = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/seg_display_ctrl.sv
// Captures a binary value, converts it to decimal or hex glyphs and scans them onto a multiplexed display.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int VALUE_W        = 16,
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                load,
  input  logic [VALUE_W-1:0]  value,
  input  logic                mode,
  input  logic                blank_lz,
  input  logic                enable,
  output logic                busy,
  output logic                overflow,
  output logic [DIGITS-1:0]   an_n,
  output logic [6:0]          seg_n
);

  localparam int SCAN_W = $clog2(REFRESH_CYCLES);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int EXT_W  = VALUE_W + 4 * DIGITS;

  logic                 hex_pending, cap_blank, accept, start, upd;
  logic [VALUE_W-1:0]   cap_value;
  logic                 conv_busy, conv_done, conv_ovf;
  logic [4*DIGITS-1:0]  conv_bcd, src_digits;
  logic [EXT_W-1:0]     ext;
  logic                 hex_ovf, src_ovf, seen;
  logic [3:0]           dig;
  logic [6:0]           disp [DIGITS];
  logic [6:0]           new_disp [DIGITS];
  logic [6:0]           disp_d [DIGITS];
  logic [SCAN_W-1:0]    scan_q;
  logic [IDX_W-1:0]     idx_q, idx_d;

  assign busy   = hex_pending | conv_busy;
  assign accept = load & ~busy;
  assign start  = accept & (mode == MODE_DEC);
  assign upd    = hex_pending | conv_done;
  assign ext    = EXT_W'(cap_value);
  assign hex_ovf = |ext[EXT_W-1:4*DIGITS];

  bin2bcd_seq #(.VALUE_W(VALUE_W), .DIGITS(DIGITS)) u_conv (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .value    (value),
    .busy     (conv_busy),
    .done     (conv_done),
    .bcd      (conv_bcd),
    .overflow (conv_ovf)
  );

  // Build the whole new glyph set at once so the display updates atomically
  always_comb begin
    src_digits = hex_pending ? ext[4*DIGITS-1:0] : conv_bcd;
    src_ovf    = hex_pending ? hex_ovf : conv_ovf;
    seen       = 1'b0;
    dig        = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dig = src_digits[4*k +: 4];
      if (src_ovf)                                  new_disp[k] = SEG_DASH;
      else if (cap_blank && !seen && dig == 4'd0 && k != 0) new_disp[k] = SEG_BLANK;
      else                                          new_disp[k] = glyph(dig);
      if (dig != 4'd0) seen = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hex_pending <= 1'b0;
      cap_blank   <= 1'b0;
      cap_value   <= '0;
      overflow    <= 1'b0;
      for (int k = 0; k < DIGITS; k++) disp[k] <= SEG_BLANK;
    end else begin
      hex_pending <= accept & (mode == MODE_HEX);
      if (accept) begin
        cap_value <= value;
        cap_blank <= blank_lz;
      end
      if (upd) begin
        disp     <= new_disp;
        overflow <= src_ovf;
      end
    end
  end

  // Outputs are registered from next-state values so they track index and display on the same edge
  always_comb begin
    disp_d = disp;
    if (upd) disp_d = new_disp;
    idx_d = idx_q;
    if (scan_q == SCAN_W'(REFRESH_CYCLES - 1))
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_q <= '0;
      idx_q  <= '0;
      an_n   <= '1;
      seg_n  <= SEG_BLANK;
    end else begin
      scan_q <= (scan_q == SCAN_W'(REFRESH_CYCLES - 1)) ? '0 : scan_q + 1'b1;
      idx_q  <= idx_d;
      an_n   <= enable ? ~(DIGITS'(1) << idx_d) : '1;
      seg_n  <= disp_d[idx_d];
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with a short refresh period so every digit is scanned quickly.
module tb_seg_display_ctrl;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b1111110;
  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] G7 = 7'b0001111;
  localparam logic [6:0] G9 = 7'b0000100;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GF = 7'b0111000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic        enable = 1'b1;
  logic        busy, overflow;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;

  int compared = 0;
  int mismatched = 0;

  seg_display_ctrl #(.DIGITS(4), .VALUE_W(16), .REFRESH_CYCLES(3)) dut (
    .CLK(CLK), .RST(RST), .load(load), .value(value), .mode(mode),
    .blank_lz(blank_lz), .enable(enable), .busy(busy), .overflow(overflow),
    .an_n(an_n), .seg_n(seg_n)
  );

  always #5 CLK = ~CLK;

  task automatic issue_load(input logic [15:0] v, input logic m, input logic b);
    load = 1'b1; value = v; mode = m; blank_lz = b;
    @(negedge CLK);
    load = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic read_digits(output logic [27:0] g);
    logic [3:0] seen = '0;
    int n = 0;
    g = '0;
    while (seen != 4'hF && n < 40) begin
      for (int k = 0; k < 4; k++)
        if (an_n === ~(4'b0001 << k)) begin g[7*k +: 7] = seg_n; seen[k] = 1'b1; end
      n++;
      @(negedge CLK);
    end
    if (seen != 4'hF) begin
      compared++; mismatched++;
      $display("[TB] FAIL scan_timeout digits seen=%b required=1111", seen);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    @(negedge CLK); @(negedge CLK);
    compared++;
    if ({an_n, seg_n, busy, overflow} !== {4'hF, BL, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_state an_n=%b seg_n=%b busy=%b ovf=%b required 1111/1111111/0/0",
               an_n, seg_n, busy, overflow);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic check_display(input string name, input logic [27:0] exp, input logic exp_ovf);
    logic [27:0] g;
    read_digits(g);
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (g[7*k +: 7] !== exp[7*k +: 7]) begin
        mismatched++;
        $display("[TB] FAIL %s digit%0d seg_n=%b required=%b", name, k, g[7*k +: 7], exp[7*k +: 7]);
      end
    end
    compared++;
    if (overflow !== exp_ovf) begin
      mismatched++;
      $display("[TB] FAIL %s overflow=%b required=%b", name, overflow, exp_ovf);
    end
  endtask

  task automatic test_decimal;
    int n;
    issue_load(16'd1234, 1'b0, 1'b0);
    wait_busy(n);
    compared++;
    if (n != 17) begin mismatched++; $display("[TB] FAIL dec_busy_len got=%0d required=17", n); end
    check_display("dec_1234", {G1, G2, G3, G4}, 1'b0);
  endtask

  task automatic test_hex;
    int n;
    issue_load(16'h00AF, 1'b1, 1'b1);
    wait_busy(n);
    compared++;
    if (n != 1) begin mismatched++; $display("[TB] FAIL hex_busy_len got=%0d required=1", n); end
    check_display("hex_00AF", {BL, BL, GA, GF}, 1'b0);
  endtask

  task automatic test_overflow;
    int n;
    issue_load(16'd12345, 1'b0, 1'b0);
    wait_busy(n);
    compared++;
    if (n != 17) begin mismatched++; $display("[TB] FAIL ovf_busy_len got=%0d required=17", n); end
    check_display("dec_12345", {DS, DS, DS, DS}, 1'b1);
  endtask

  // Starts while overflow=1 from the previous value; that flag must hold until the update edge
  task automatic test_back_to_back;
    issue_load(16'd1234, 1'b0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      compared++;
      if (busy !== 1'b1 || overflow !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL b2b_hold cycle%0d busy=%b ovf=%b required 1/1", k, busy, overflow);
      end
      if (k == 5)  begin load = 1'b1; value = 16'd4321; end
      if (k == 6)  load = 1'b0;
      if (k == 17) begin load = 1'b1; value = 16'd5555; end
      @(negedge CLK);
    end
    load = 1'b0;
    compared++;
    if (busy !== 1'b0 || overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_clear busy=%b ovf=%b required 0/0", busy, overflow);
    end
    check_display("b2b_1234", {G1, G2, G3, G4}, 1'b0);
  endtask

  task automatic test_blanking;
    logic [15:0] vals [3] = '{16'd0, 16'd705, 16'd9999};
    logic        blk  [3] = '{1'b1, 1'b1, 1'b0};
    logic [27:0] exps [3] = '{{BL, BL, BL, G0}, {BL, G7, G0, G5}, {G9, G9, G9, G9}};
    int n;
    for (int i = 0; i < 3; i++) begin
      issue_load(vals[i], 1'b0, blk[i]);
      wait_busy(n);
      check_display($sformatf("blank_%0d", vals[i]), exps[i], 1'b0);
    end
  endtask

  task automatic test_scan;
    logic [3:0] seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [3:0] prev;
    int n = 0;
    prev = an_n;
    @(negedge CLK);
    while (!(an_n === 4'b1110 && prev === 4'b0111) && n < 40) begin
      prev = an_n;
      @(negedge CLK);
      n++;
    end
    compared++;
    if (n >= 40) begin mismatched++; $display("[TB] FAIL scan_sync an_n=%b required=1110", an_n); end
    for (int i = 0; i < 15; i++) begin
      compared++;
      if (an_n !== seq[i/3]) begin
        mismatched++;
        $display("[TB] FAIL scan_seq step%0d an_n=%b required=%b", i, an_n, seq[i/3]);
      end
      @(negedge CLK);
    end
    enable = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (an_n !== 4'hF) begin mismatched++; $display("[TB] FAIL scan_disabled an_n=%b required=1111", an_n); end
      @(negedge CLK);
    end
    enable = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    int n;
    issue_load(16'd12345, 1'b0, 1'b0);
    wait_busy(n);
    issue_load(16'd9999, 1'b0, 1'b0);
    for (int k = 1; k < 5; k++) @(negedge CLK);
    RST = 1'b1; load = 1'b1; value = 16'd1;
    @(negedge CLK);
    compared++;
    if ({busy, overflow, an_n, seg_n} !== {1'b0, 1'b0, 4'hF, BL}) begin
      mismatched++;
      $display("[TB] FAIL rst_mid busy=%b ovf=%b an_n=%b seg_n=%b required 0/0/1111/1111111",
               busy, overflow, an_n, seg_n);
    end
    RST = 1'b0; load = 1'b0;
    @(negedge CLK);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_idle busy=%b required=0", busy); end
    check_display("rst_mid_blank", {BL, BL, BL, BL}, 1'b0);
  endtask

  initial begin
    test_reset;
    test_decimal;
    test_hex;
    test_overflow;
    test_back_to_back;
    test_blanking;
    test_scan;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter VALUE_W, default 16, binary input width (4..32).
REQ-003 SHALL have parameter REFRESH_CYCLES, default 50000, CLK cycles per digit slot (>=2).
REQ-004 SHALL have port CLK  input  1  sole clock, all state on posedge.
REQ-005 SHALL have port RST  input  1  reset; one clock, synchronous, active-high.
REQ-006 SHALL have port load  input  1  capture strobe for value/mode/blank_lz.
REQ-007 SHALL have port value  input  VALUE_W  binary number to display.
REQ-008 SHALL have port mode  input  1  0 = decimal, 1 = hexadecimal.
REQ-009 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-010 SHALL have port enable  input  1  0 forces all anodes off; scanning continues.
REQ-011 SHALL have port busy  output  1  conversion in progress, load ignored.
REQ-012 SHALL have port overflow  output  1  last captured value does not fit DIGITS.
REQ-013 SHALL have port an_n  output  DIGITS  active-low digit enables, bit 0 = least significant digit.
REQ-014 SHALL have port seg_n  output  7  active-low segments, bit 6..0 = a,b,c,d,e,f,g.

Function
REQ-015 SHALL capture value/mode/blank_lz on an edge with load=1 and busy=0; load while busy=1 SHALL be ignored, with no queuing.
REQ-016 Decimal: SHALL convert by sequential shift-add-3 (double-dabble), one bit per cycle; busy=1 for exactly VALUE_W+1 cycles after the capture edge; display registers and overflow update on the edge that clears busy.
REQ-017 Hex: busy=1 for exactly 1 cycle; digit k = value[4k+3:4k]; update on the edge that clears busy.
REQ-018 Display registers SHALL change atomically; the previous contents are shown until the update edge.
REQ-019 Overflow (decimal value >= 10^DIGITS, or hex value bits above 4*DIGITS-1 nonzero): overflow=1, every digit shows '-' (g only); otherwise overflow=0.
REQ-020 Glyphs: 0-9 standard (0 = abcdef); A,b,C,d,E,F for 10-15; blank = all segments off.
REQ-021 blank_lz=1: zero digits above the most significant nonzero digit show blank; digit 0 is never blanked (value 0 shows "0").
REQ-022 Scan counter SHALL count 0..REFRESH_CYCLES-1; on terminal count it wraps to 0 and the digit index advances, DIGITS-1 wrapping to 0; index never exceeds DIGITS-1.
REQ-023 an_n SHALL have exactly one bit low (current index) when enable=1, and all bits high when enable=0; seg_n SHALL show the glyph of the current index; both registered, changing on the same edge as the index.
REQ-024 load arriving on the same edge that clears busy SHALL be ignored; it is accepted on the next edge.

Reset
REQ-025 RST=1 SHALL set an_n all ones, seg_n all ones, busy=0, overflow=0, scan counter 0, digit index 0, and all display registers blank.
REQ-026 RST mid-conversion SHALL abort it; display registers are not updated.
REQ-027 RST SHALL take priority over load on the same edge.

Structure
REQ-028 Glyph constants (0-F, blank, dash) and mode encodings SHALL live in shared package seg_pkg.
REQ-029 Double-dabble converter SHALL be sub-module bin2bcd_seq (start/busy/done, parametrised VALUE_W, DIGITS) instantiated once.

Verification
REQ-030 Defaults, decimal, value=1234, blank_lz=0 -> busy high 17 cycles; then digits 3..0 = 1,2,3,4; digit 0 seg_n=7'b1001100; overflow=0.
REQ-031 Hex, value=16'h00AF, blank_lz=1 -> busy 1 cycle; digits 3..0 = blank, blank, A, F.
REQ-032 Decimal, value=12345 with DIGITS=4 -> overflow=1, all digits '-' (seg_n=7'b1111110).
REQ-033 REFRESH_CYCLES=3, enable=1 -> an_n sequence 1110,1101,1011,0111,1110, 3 cycles each; enable=0 -> an_n=1111.
REQ-034 load during busy with a different value -> ignored; the first value is displayed; load on the busy-clearing edge -> ignored.
REQ-035 RST asserted at conversion cycle 5 -> busy=0 next cycle; display blank; overflow=0.
